// File: rtl/fp_div_sequencer.sv
// fp_div_sequencer: clocked front/back-end for a combinational single-precision
// Newton-Raphson divider. Special operands (NaN, zero, infinity, out-of-range
// exponents) are answered directly. Ordinary operand pairs are held on div_*
// for SETTLE_CYCLES cycles, and the quotient is then captured into the output
// register.
// Optional feature macro: FP_DIV_STICKY_FLAGS_EN adds an accumulating flag
// register (sticky_flags) with a synchronous clear input (flags_clear).
module fp_div_sequencer #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_numerator,
   input  logic [31:0] in_divisor,
   output logic [31:0] div_numerator,
   output logic [31:0] div_divisor,
   input  logic [31:0] div_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_quotient,
   output logic [3:0]  out_flags
`ifdef FP_DIV_STICKY_FLAGS_EN
   ,
   input  logic        flags_clear,
   output logic [3:0]  sticky_flags
`endif
);

   // Flag bit positions within out_flags.
   localparam int F_INVALID = 0;
   localparam int F_DIVZERO = 1;
   localparam int F_OVERFLOW = 2;
   localparam int F_UNDERFLOW = 3;

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   // The counter is 4 bits wide; keep the load value inside 1..15.
   localparam int unsigned CNT_CLAMP = (SETTLE_CYCLES < 1)  ? 1 :
                                       (SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES;
   localparam logic [3:0] CNT_LOAD = 4'(CNT_CLAMP);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

   state_t     state;
   logic [3:0] settle_cnt;

   // Operand classification. A zero exponent field flushes denormals to zero.
   function automatic logic is_zero(input logic [31:0] x);
      return (x[30:23] == 8'h00);
   endfunction

   function automatic logic is_inf(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
   endfunction

   function automatic logic is_nan(input logic [31:0] x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

   // Pre-normalisation exponent estimate of the quotient, biased by 126.
   function automatic logic signed [9:0] range_t(input logic [7:0] ne,
                                                 input logic [7:0] de);
      return $signed({2'b00, ne}) - $signed({2'b00, de}) + 10'sd126;
   endfunction

   // Saturate a divider result whose exponent reached all-ones to a clean infinity.
   function automatic logic [31:0] sat_quotient(input logic [31:0] r);
      if (r[30:23] == 8'hFF) begin
         return {r[31], 8'hFF, 23'd0};
      end
      return r;
   endfunction

   function automatic logic [3:0] sat_flags(input logic [31:0] r);
      logic [3:0] f;
      f = 4'b0000;
      if (r[30:23] == 8'hFF) begin
         f[F_OVERFLOW] = 1'b1;
      end
      return f;
   endfunction

   logic               byp_hit;
   logic [31:0]        byp_q;
   logic [3:0]         byp_f;
   logic               res_sign;
   logic               n_zero, n_inf, n_nan;
   logic               d_zero, d_inf, d_nan;
   logic signed [9:0]  t_exp;

   assign in_ready = (state == IDLE);

   // Screen the offered operand pair for results that bypass the divider (first match wins).
   always_comb begin
      res_sign = in_numerator[31] ^ in_divisor[31];
      n_zero   = is_zero(in_numerator);
      n_inf    = is_inf(in_numerator);
      n_nan    = is_nan(in_numerator);
      d_zero   = is_zero(in_divisor);
      d_inf    = is_inf(in_divisor);
      d_nan    = is_nan(in_divisor);
      t_exp    = range_t(in_numerator[30:23], in_divisor[30:23]);
      byp_hit  = 1'b0;
      byp_q    = 32'd0;
      byp_f    = 4'b0000;
      if (n_nan || d_nan) begin
         byp_hit            = 1'b1;
         byp_q              = QNAN;
         byp_f[F_INVALID]   = 1'b1;
      end else if ((n_zero && d_zero) || (n_inf && d_inf)) begin
         byp_hit            = 1'b1;
         byp_q              = QNAN;
         byp_f[F_INVALID]   = 1'b1;
      end else if (!n_zero && !n_inf && d_zero) begin
         byp_hit            = 1'b1;
         byp_q              = {res_sign, 8'hFF, 23'd0};
         byp_f[F_DIVZERO]   = 1'b1;
      end else if (n_inf) begin
         byp_hit            = 1'b1;
         byp_q              = {res_sign, 8'hFF, 23'd0};
      end else if (n_zero || d_inf) begin
         byp_hit            = 1'b1;
         byp_q              = {res_sign, 31'd0};
      end else if (t_exp >= 10'sd254) begin
         byp_hit            = 1'b1;
         byp_q              = {res_sign, 8'hFF, 23'd0};
         byp_f[F_OVERFLOW]  = 1'b1;
      end else if (t_exp <= 10'sd0) begin
         byp_hit            = 1'b1;
         byp_q              = {res_sign, 31'd0};
         byp_f[F_UNDERFLOW] = 1'b1;
      end
   end

   // Sequencer FSM: accept, settle the divider, capture and hold the result.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         settle_cnt    <= 4'd0;
         div_numerator <= 32'd0;
         div_divisor   <= 32'd0;
         out_valid     <= 1'b0;
         out_quotient  <= 32'd0;
         out_flags     <= 4'b0000;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (byp_hit) begin
                     out_quotient <= byp_q;
                     out_flags    <= byp_f;
                     out_valid    <= 1'b1;
                     state        <= HOLD;
                  end else begin
                     div_numerator <= in_numerator;
                     div_divisor   <= in_divisor;
                     settle_cnt    <= CNT_LOAD;
                     state         <= SETTLE;
                  end
               end
            end
            SETTLE: begin
               if (settle_cnt == 4'd1) begin
                  out_quotient <= sat_quotient(div_result);
                  out_flags    <= sat_flags(div_result);
                  out_valid    <= 1'b1;
                  settle_cnt   <= 4'd0;
                  state        <= HOLD;
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

`ifdef FP_DIV_STICKY_FLAGS_EN
   logic out_hs;
   assign out_hs = out_valid && out_ready;

   // Accumulate flags of delivered results; a clear keeps only the flags delivered this cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sticky_flags <= 4'b0000;
      end else if (flags_clear) begin
         sticky_flags <= out_hs ? out_flags : 4'b0000;
      end else if (out_hs) begin
         sticky_flags <= sticky_flags | out_flags;
      end
   end
`else
   // No sticky flag register in this build.
`endif

endmodule

// File: tb/tb_fp_div_sequencer.sv
// tb_fp_div_sequencer: directed, table-driven bench for fp_div_sequencer with
// a truncating behavioural divider standing in for the combinational divider.
module tb_fp_div_sequencer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_numerator;
   logic [31:0] in_divisor;
   logic [31:0] div_numerator;
   logic [31:0] div_divisor;
   logic [31:0] div_result;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_quotient;
   logic [3:0]  out_flags;
`ifdef FP_DIV_STICKY_FLAGS_EN
   logic        flags_clear;
   logic [3:0]  sticky_flags;
`endif

   logic        force_en;
   logic [31:0] force_val;

   int tests;
   int fails;

   // Truncating FP32 divide for normal operands.
   function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
      logic [49:0] q;
      logic [22:0] m;
      int          e;
      q = ({26'd0, 1'b1, a[22:0]} << 25) / {26'd0, 1'b1, b[22:0]};
      if (q[25]) begin
         m = q[24:2];
         e = int'(a[30:23]) - int'(b[30:23]) + 127;
      end else begin
         m = q[23:1];
         e = int'(a[30:23]) - int'(b[30:23]) + 126;
      end
      if (e >= 255) return {a[31] ^ b[31], 8'hFF, m};
      if (e <= 0) return {a[31] ^ b[31], 31'd0};
      return {a[31] ^ b[31], e[7:0], m};
   endfunction

   assign div_result = force_en ? force_val : fdiv(div_numerator, div_divisor);

   fp_div_sequencer #(.SETTLE_CYCLES(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_numerator  (in_numerator),
      .in_divisor    (in_divisor),
      .div_numerator (div_numerator),
      .div_divisor   (div_divisor),
      .div_result    (div_result),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_quotient  (out_quotient),
      .out_flags     (out_flags)
`ifdef FP_DIV_STICKY_FLAGS_EN
      ,
      .flags_clear   (flags_clear),
      .sticky_flags  (sticky_flags)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] num;
      logic [31:0] den;
      logic [31:0] q;
      logic [3:0]  f;
      int          lat;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs[NV];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Offer one operand pair starting #1 after an edge; return when out_valid
   // rises or the cycle budget runs out. lat counts edges from accept inclusive.
   task automatic run_op(input logic [31:0] num, input logic [31:0] den,
                         output logic [31:0] q, output logic [3:0] f, output int lat);
      in_numerator = num;
      in_divisor   = den;
      in_valid     = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      q = out_quotient;
      f = out_flags;
   endtask

   logic [31:0] q_got, prev_n, prev_d, q_hold;
   logic [3:0]  f_got, f_hold;
   int          lat_got;

   initial begin
      tests        = 0;
      fails        = 0;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      in_numerator = 32'd0;
      in_divisor   = 32'd0;
      out_ready    = 1'b1;
      force_en     = 1'b0;
      force_val    = 32'd0;
`ifdef FP_DIV_STICKY_FLAGS_EN
      flags_clear  = 1'b0;
`endif

      //             num            den            q              f        lat
      vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 5};
      vecs[1]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010, 1};
      vecs[2]  = '{32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0010, 1};
      vecs[3]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b0001, 1};
      vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001, 1};
      vecs[5]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0001, 1};
      vecs[6]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0100, 1};
      vecs[7]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 4'b1000, 1};
      vecs[8]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 4'b0000, 1};
      vecs[9]  = '{32'hFF800000, 32'h00000000, 32'hFF800000, 4'b0000, 1};
      vecs[10] = '{32'h00000000, 32'hC0400000, 32'h80000000, 4'b0000, 1};
      vecs[11] = '{32'h40A00000, 32'h7F800000, 32'h00000000, 4'b0000, 1};
      vecs[12] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 5};
      vecs[13] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1};
      vecs[14] = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 5};
      vecs[15] = '{32'h7F000000, 32'h3F000000, 32'h7F800000, 4'b0100, 1};
      vecs[16] = '{32'h7F000000, 32'h3F800000, 32'h7F000000, 4'b0000, 5};
      vecs[17] = '{32'h01000000, 32'h3F800000, 32'h01000000, 4'b0000, 5};
      vecs[18] = '{32'h00800000, 32'h3F800000, 32'h00000000, 4'b1000, 1};
      vecs[19] = '{32'h3F800000, 32'h7FA00000, 32'h7FC00000, 4'b0001, 1};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_quotient", out_quotient, 32'd0);
      chk("rst_flags", {28'd0, out_flags}, 32'd0);
      chk("rst_div_num", div_numerator, 32'd0);
      chk("rst_div_den", div_divisor, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table of single transactions with immediate downstream acceptance
      for (int i = 0; i < NV; i++) begin
         prev_n = div_numerator;
         prev_d = div_divisor;
         chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
         run_op(vecs[i].num, vecs[i].den, q_got, f_got, lat_got);
         chk($sformatf("v%0d_latency", i), lat_got, vecs[i].lat);
         chk($sformatf("v%0d_quotient", i), q_got, vecs[i].q);
         chk($sformatf("v%0d_flags", i), {28'd0, f_got}, {28'd0, vecs[i].f});
         if (vecs[i].lat > 1) begin
            chk($sformatf("v%0d_div_num", i), div_numerator, vecs[i].num);
            chk($sformatf("v%0d_div_den", i), div_divisor, vecs[i].den);
         end else begin
            chk($sformatf("v%0d_div_num_kept", i), div_numerator, prev_n);
            chk($sformatf("v%0d_div_den_kept", i), div_divisor, prev_d);
         end
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_valid_drop", i), {31'd0, out_valid}, 32'd0);
      end

      // Divider operands appear one cycle after accept and stay put while settling
      in_numerator = 32'h40C00000;
      in_divisor   = 32'h40000000;
      in_valid     = 1'b1;
      @(posedge clk);
      #1;
      in_valid     = 1'b0;
      in_numerator = 32'h12345678;
      in_divisor   = 32'h3F800000;
      for (int c = 1; c <= 4; c++) begin
         chk($sformatf("settle%0d_div_num", c), div_numerator, 32'h40C00000);
         chk($sformatf("settle%0d_div_den", c), div_divisor, 32'h40000000);
         chk($sformatf("settle%0d_valid", c), {31'd0, out_valid}, 32'd0);
         @(posedge clk);
         #1;
      end
      chk("settle_valid_rise", {31'd0, out_valid}, 32'd1);
      @(posedge clk);
      #1;

      // Backpressure: result held stable, input blocked until downstream accepts
      out_ready = 1'b0;
      run_op(32'h40C00000, 32'h40000000, q_got, f_got, lat_got);
      chk("bp_latency", lat_got, 5);
      q_hold = q_got;
      f_hold = f_got;
      chk("bp_quotient", q_got, 32'h40400000);
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d_valid", c), {31'd0, out_valid}, 32'd1);
         chk($sformatf("bp%0d_quotient", c), out_quotient, q_hold);
         chk($sformatf("bp%0d_flags", c), {28'd0, out_flags}, {28'd0, f_hold});
         chk($sformatf("bp%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_valid_drop", {31'd0, out_valid}, 32'd0);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd1);

      // Divider result with all-ones exponent saturates to infinity with overflow
      force_en  = 1'b1;
      force_val = 32'hFF812345;
      run_op(32'h40C00000, 32'h40000000, q_got, f_got, lat_got);
      chk("sat_latency", lat_got, 5);
      chk("sat_quotient", q_got, 32'hFF800000);
      chk("sat_flags", {28'd0, f_got}, 32'h4);
      force_en = 1'b0;
      @(posedge clk);
      #1;

      // Reset while settling (counter at 2) aborts the transaction
      in_numerator = 32'h40C00000;
      in_divisor   = 32'h40000000;
      in_valid     = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("abort_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_quotient", out_quotient, 32'd0);
      chk("abort_flags", {28'd0, out_flags}, 32'd0);
      chk("abort_div_num", div_numerator, 32'd0);
      chk("abort_div_den", div_divisor, 32'd0);
      chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
      begin
         int seen;
         seen = 0;
         for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
         end
         chk("abort_no_valid", seen, 0);
      end

`ifdef FP_DIV_STICKY_FLAGS_EN
      // Sticky flags accumulate across results and clear on request
      flags_clear = 1'b1;
      @(posedge clk);
      #1;
      flags_clear = 1'b0;
      chk("sticky_cleared", {28'd0, sticky_flags}, 32'd0);
      run_op(32'h3F800000, 32'h00000000, q_got, f_got, lat_got);
      @(posedge clk);
      #1;
      run_op(32'h00800000, 32'h7F000000, q_got, f_got, lat_got);
      @(posedge clk);
      #1;
      chk("sticky_accum", {28'd0, sticky_flags}, 32'hA);
      flags_clear = 1'b1;
      @(posedge clk);
      #1;
      flags_clear = 1'b0;
      chk("sticky_clear", {28'd0, sticky_flags}, 32'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
